// File: rtl/sigma_pkg.sv
// Shared constants and helpers for the sigma multiplexed accumulator.
package sigma_pkg;

   localparam int DW_DEF       = 8;
   localparam int WIN_LOG2_DEF = 4;

   // Result width: sample width plus enough headroom for a full window.
   function automatic int ow_of(input int dw, input int win_log2);
      return dw + win_log2;
   endfunction

   localparam int OW_DEF = ow_of(DW_DEF, WIN_LOG2_DEF);

   // Sign-magnitude (sign in bit dw-1) to two's complement, sign-extended
   // to 32 bits. Negative zero maps to zero because -0 == 0.
   function automatic logic signed [31:0] sm_to_tc(input logic [31:0] sm,
                                                   input int          dw);
      logic [31:0] mag;
      logic        sgn;
      mag = sm & ((32'd1 << (dw - 1)) - 32'd1);
      sgn = sm[dw-1];
      if (sgn)
         return -$signed(mag);
      else
         return $signed(mag);
   endfunction

endpackage

// File: rtl/sigma_rr_arb.sv
// Round-robin arbiter: grants one requester per cycle, search starts at ptr.
module sigma_rr_arb
#(
   parameter  int NCH = 4,
   localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
)
(
   input  logic           clk,
   input  logic           res,
   input  logic           clr,
   input  logic [NCH-1:0] req,
   output logic [NCH-1:0] gnt_oh,
   output logic [CW-1:0]  gnt_idx,
   output logic           gnt_vld
);

   logic [CW-1:0] ptr;

   // First pending requester found walking upward from ptr with wrap.
   always_comb begin
      int            j;
      logic [CW-1:0] j_idx;
      j       = 0;
      j_idx   = '0;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int i = 0; i < NCH; i++) begin
         j     = (int'(ptr) + i) % NCH;
         j_idx = CW'(j);
         if (!gnt_vld && req[j_idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = j_idx;
         end
      end
   end

   assign gnt_oh = gnt_vld ? (NCH'(1) << gnt_idx) : '0;

   // Pointer moves just past the last winner; holds when idle.
   always_ff @(posedge clk or posedge res) begin
      if (res)
         ptr <= '0;
      else if (clr)
         ptr <= '0;
      else if (gnt_vld)
         ptr <= (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
   end

endmodule

// File: rtl/sigma_mux_sched.sv
// Time-shared window accumulator: NCH sample channels share one adder,
// each emits a tagged sum every 2**WIN_LOG2 accepted samples.
module sigma_mux_sched
   import sigma_pkg::*;
#(
   parameter  int NCH      = 4,
   parameter  int DW       = DW_DEF,
   parameter  int WIN_LOG2 = WIN_LOG2_DEF,
   localparam int OW       = ow_of(DW, WIN_LOG2),
   localparam int CW       = (NCH > 1) ? $clog2(NCH) : 1
)
(
   input  logic              clk,
   input  logic              res,
   input  logic              clr,
   input  logic [NCH*DW-1:0] data_in,
   input  logic [NCH-1:0]    syn_in,
   output logic [OW-1:0]     data_out,
   output logic [CW-1:0]     ch_out,
   output logic              syn_out,
   output logic [NCH-1:0]    overrun
);

   localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;

   logic [NCH-1:0]       syn_q;
   logic [NCH-1:0]       edge_v;
   logic [NCH-1:0]       pend;
   logic [NCH-1:0]       gnt_oh;
   logic [CW-1:0]        gnt_idx;
   logic                 gnt_vld;
   logic [DW-1:0]        pdata [NCH];
   logic signed [OW-1:0] sum   [NCH];
   logic [WIN_LOG2-1:0]  cnt   [NCH];
   logic [DW-1:0]        gnt_data;
   logic [31:0]          tc32;
   logic signed [OW-1:0] gnt_val;
   logic signed [OW-1:0] win_sum;
   logic                 win_done;
   logic                 unused_tc_hi;

   sigma_rr_arb #(.NCH(NCH)) u_arb (
      .clk     (clk),
      .res     (res),
      .clr     (clr),
      .req     (pend),
      .gnt_oh  (gnt_oh),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   assign edge_v   = syn_in & ~syn_q;
   assign gnt_data = pdata[gnt_idx];
   assign tc32     = sm_to_tc({{(32-DW){1'b0}}, gnt_data}, DW);
   assign gnt_val  = tc32[OW-1:0];
   // Upper bits are pure sign extension; the window sum cannot overflow OW.
   assign unused_tc_hi = ^tc32[31:OW];
   assign win_done = gnt_vld && (cnt[gnt_idx] == CNT_LAST);
   assign win_sum  = sum[gnt_idx] + gnt_val;

   // Strobe edge detect, sample capture, pending and sticky overrun flags.
   // A grant and a new edge in the same cycle keep pend set without overrun.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         syn_q   <= '0;
         pend    <= '0;
         overrun <= '0;
         for (int c = 0; c < NCH; c++)
            pdata[c] <= '0;
      end else if (clr) begin
         syn_q   <= '0;
         pend    <= '0;
         overrun <= '0;
         for (int c = 0; c < NCH; c++)
            pdata[c] <= '0;
      end else begin
         syn_q   <= syn_in;
         pend    <= edge_v | (pend & ~gnt_oh);
         overrun <= overrun | (edge_v & pend & ~gnt_oh);
         for (int c = 0; c < NCH; c++)
            if (edge_v[c])
               pdata[c] <= data_in[c*DW +: DW];
      end
   end

   // Per-channel partial sums and sample counts, updated only for the grantee.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         for (int c = 0; c < NCH; c++) begin
            sum[c] <= '0;
            cnt[c] <= '0;
         end
      end else if (clr) begin
         for (int c = 0; c < NCH; c++) begin
            sum[c] <= '0;
            cnt[c] <= '0;
         end
      end else if (gnt_vld) begin
         if (win_done) begin
            sum[gnt_idx] <= '0;
            cnt[gnt_idx] <= '0;
         end else begin
            sum[gnt_idx] <= win_sum;
            cnt[gnt_idx] <= cnt[gnt_idx] + 1'b1;
         end
      end
   end

   // Result register: pulse on window completion, hold value and tag otherwise.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         data_out <= '0;
         ch_out   <= '0;
         syn_out  <= 1'b0;
      end else if (clr) begin
         data_out <= '0;
         ch_out   <= '0;
         syn_out  <= 1'b0;
      end else begin
         syn_out <= win_done;
         if (win_done) begin
            data_out <= win_sum;
            ch_out   <= gnt_idx;
         end
      end
   end

endmodule

// File: tb/tb_sigma_mux_sched.sv
// Directed bench for sigma_mux_sched (NCH=4, DW=8, OW=12).
module tb_sigma_mux_sched;

   logic        clk;
   logic        res;
   logic        clr;
   logic [31:0] data_in;
   logic [3:0]  syn_in;
   logic [11:0] data_out;
   logic [1:0]  ch_out;
   logic        syn_out;
   logic [3:0]  overrun;

   typedef struct packed {
      logic [1:0]  ch;
      logic [11:0] data;
   } ev_t;

   ev_t evq[$];
   int  n_checks = 0;
   int  n_fail   = 0;

   sigma_mux_sched #(.NCH(4), .DW(8), .WIN_LOG2(4)) dut (
      .clk      (clk),
      .res      (res),
      .clr      (clr),
      .data_in  (data_in),
      .syn_in   (syn_in),
      .data_out (data_out),
      .ch_out   (ch_out),
      .syn_out  (syn_out),
      .overrun  (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every result pulse for later window checks.
   always @(negedge clk)
      if (syn_out === 1'b1)
         evq.push_back('{ch: ch_out, data: data_out});

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic strobe(input int ch, input logic [7:0] val, input int gap);
      data_in[ch*8 +: 8] = val;
      syn_in[ch] = 1'b1;
      tick();
      syn_in[ch] = 1'b0;
      repeat (gap - 1) tick();
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      tick();
   endtask

   task automatic expect_one(input string tag, input logic [1:0] ech, input logic [11:0] edata);
      ev_t ev;
      ev = 'x;
      chk({tag, "_count"}, evq.size(), 1);
      if (evq.size() > 0)
         ev = evq.pop_front();
      chk({tag, "_ch"}, ev.ch, ech);
      chk({tag, "_data"}, ev.data, edata);
      evq.delete();
   endtask

   initial begin
      res     = 1'b1;
      clr     = 1'b0;
      syn_in  = '0;
      data_in = '0;

      // Reset state
      repeat (3) tick();
      chk("rst_data", data_out, 12'h000);
      chk("rst_ch", ch_out, 2'd0);
      chk("rst_syn", syn_out, 1'b0);
      chk("rst_ovr", overrun, 4'h0);
      res = 1'b0;
      repeat (2) tick();

      // Ch0, +1 x16, with exact latency on the completing strobe
      repeat (15) strobe(0, 8'h01, 20);
      chk("ch0_early", evq.size(), 0);
      data_in[7:0] = 8'h01;
      syn_in[0] = 1'b1;
      tick();
      syn_in[0] = 1'b0;
      chk("ch0_lat_n1", syn_out, 1'b0);
      tick();
      chk("ch0_lat_n2", syn_out, 1'b1);
      chk("ch0_ch", ch_out, 2'd0);
      chk("ch0_data", data_out, 12'h010);
      tick();
      chk("ch0_pulse_end", syn_out, 1'b0);
      chk("ch0_hold", data_out, 12'h010);
      evq.delete();
      repeat (5) tick();

      // Ch2 sign-magnitude values
      repeat (16) strobe(2, 8'h81, 20);
      expect_one("ch2_m1", 2'd2, 12'hFF0);
      repeat (16) strobe(2, 8'h7F, 20);
      expect_one("ch2_p127", 2'd2, 12'h7F0);
      repeat (16) strobe(2, 8'hFF, 20);
      expect_one("ch2_m127", 2'd2, 12'h810);

      // All channels strobe together; results in consecutive cycles ch0..ch3
      pulse_clr();
      data_in = {8'h04, 8'h03, 8'h02, 8'h01};
      repeat (15) begin
         syn_in = 4'hF;
         tick();
         syn_in = 4'h0;
         repeat (19) tick();
      end
      chk("all_early", evq.size(), 0);
      syn_in = 4'hF;
      tick();
      syn_in = 4'h0;
      chk("all_n1", syn_out, 1'b0);
      for (int c = 0; c < 4; c++) begin
         tick();
         chk($sformatf("all_syn%0d", c), syn_out, 1'b1);
         chk($sformatf("all_ch%0d", c), ch_out, c[1:0]);
         chk($sformatf("all_sum%0d", c), data_out, 12'(16 * (c + 1)));
      end
      tick();
      chk("all_end", syn_out, 1'b0);
      evq.delete();
      repeat (5) tick();

      // Overrun on ch1 while ch2/ch3/ch0 hold the adder
      pulse_clr();
      repeat (14) strobe(1, 8'h01, 20);
      data_in = {8'h01, 8'h01, 8'h40, 8'h01};
      syn_in = 4'hF;
      tick();
      syn_in = 4'h0;
      tick();
      data_in[15:8] = 8'h03;
      syn_in = 4'b0010;
      tick();
      syn_in = 4'h0;
      chk("ovr_flag", overrun, 4'b0010);
      repeat (18) tick();
      chk("ovr_early", evq.size(), 0);
      strobe(1, 8'h01, 20);
      expect_one("ovr_win", 2'd1, 12'h012);
      chk("ovr_sticky", overrun, 4'b0010);
      pulse_clr();
      chk("ovr_clr", overrun, 4'h0);
      chk("clr_data", data_out, 12'h000);

      // Mid-window reset discards the partial sum
      repeat (16) strobe(2, 8'h01, 20);
      expect_one("pre_rst", 2'd2, 12'h010);
      repeat (7) strobe(0, 8'h05, 20);
      #2;
      res = 1'b1;
      #1;
      chk("arst_data", data_out, 12'h000);
      chk("arst_ch", ch_out, 2'd0);
      chk("arst_syn", syn_out, 1'b0);
      repeat (3) tick();
      chk("arst_hold", data_out, 12'h000);
      chk("arst_ovr", overrun, 4'h0);
      res = 1'b0;
      tick();
      chk("rst_noev", evq.size(), 0);
      repeat (16) strobe(0, 8'h02, 20);
      expect_one("rst_win", 2'd0, 12'h020);

      // Negative zero counts as zero
      repeat (16) strobe(3, 8'h80, 20);
      expect_one("negzero", 2'd3, 12'h000);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
